// File: rtl/ground_seg_if.sv
// Point stream bus between a raster point source and ground_seg, carrying
// the input beat, the classified output beat and their valid/ready pairs.
interface ground_seg_if #(
  parameter int W     = 16,
  parameter int COL_W = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic [7:0]              in_row;
  logic [COL_W-1:0]        in_col;
  logic signed [W-1:0]     in_x;
  logic signed [W-1:0]     in_y;
  logic signed [W-1:0]     in_z;

  logic                    out_valid;
  logic                    out_ready;
  logic [7:0]              out_row;
  logic [COL_W-1:0]        out_col;
  logic signed [W-1:0]     out_x;
  logic signed [W-1:0]     out_y;
  logic signed [W-1:0]     out_z;
  logic                    out_is_ground;

  modport master (
    output in_valid, in_row, in_col, in_x, in_y, in_z, out_ready,
    input  in_ready, out_valid, out_row, out_col, out_x, out_y, out_z, out_is_ground
  );

  modport slave (
    input  in_valid, in_row, in_col, in_x, in_y, in_z, out_ready,
    output in_ready, out_valid, out_row, out_col, out_x, out_y, out_z, out_is_ground
  );
endinterface

// File: rtl/ground_seg.sv
// Raster-order ground classifier: height test plus per-column continuity vs the row above.
// One output register stage (1-cycle latency); in_ready = !out_valid || out_ready, stalls hold output.
module ground_seg #(
  parameter int          W         = 16,
  parameter int          COLS      = 30,
  parameter int          COL_W     = 5,
  parameter int signed   Z_GND_MAX = 5,
  parameter int unsigned DZ_MAX    = 2,
  parameter int signed   Z_FLOOR   = 2
) (
  input logic         clk,
  input logic         rst,
  ground_seg_if.slave bus
);

  localparam logic signed [W-1:0] Z_GND_LIM = W'(Z_GND_MAX);
  localparam logic signed [W-1:0] Z_FLR_LIM = W'(Z_FLOOR);
  localparam logic [W:0]          DZ_LIM    = (W+1)'(DZ_MAX);

  logic [COLS-1:0]     ref_valid;
  logic [COLS-1:0]     ref_gnd;
  logic signed [W-1:0] ref_z [COLS];

  logic                out_valid_q;
  logic [7:0]          out_row_q;
  logic [COL_W-1:0]    out_col_q;
  logic signed [W-1:0] out_x_q;
  logic signed [W-1:0] out_y_q;
  logic signed [W-1:0] out_z_q;
  logic                out_gnd_q;

  logic                acc;
  logic                is_empty;
  logic                col_ok;
  logic                has_ref;
  logic                sel_valid;
  logic                sel_gnd;
  logic signed [W-1:0] sel_z;
  logic signed [W:0]   dz;
  logic [W:0]          dz_abs;
  logic                ground;
  logic                mem_wr;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign acc          = bus.in_valid && bus.in_ready;

  // Column lookup by compare rather than indexing, so out-of-range columns read nothing.
  always_comb begin
    sel_valid = 1'b0;
    sel_gnd   = 1'b0;
    sel_z     = '0;
    for (int i = 0; i < COLS; i++) begin
      if (bus.in_col == COL_W'(i)) begin
        sel_valid = ref_valid[i];
        sel_gnd   = ref_gnd[i];
        sel_z     = ref_z[i];
      end
    end
  end

  assign col_ok   = int'(bus.in_col) < COLS;
  assign is_empty = (bus.in_x == '0) && (bus.in_y == '0) && (bus.in_z == '0);
  assign has_ref  = sel_valid && (bus.in_row != 8'd0);

  // One extra bit keeps both the difference and its magnitude free of overflow.
  assign dz     = {bus.in_z[W-1], bus.in_z} - {sel_z[W-1], sel_z};
  assign dz_abs = dz[W] ? (~dz + (W+1)'(1)) : dz;

  always_comb begin
    ground = 1'b0;
    mem_wr = 1'b0;
    if (is_empty) begin
      ground = 1'b1;
    end else if (!col_ok) begin
      ground = 1'b1;
    end else if (!has_ref) begin
      ground = bus.in_z <= Z_GND_LIM;
      mem_wr = 1'b1;
    end else if (sel_gnd) begin
      ground = (bus.in_z <= Z_GND_LIM) && (dz_abs <= DZ_LIM);
      mem_wr = 1'b1;
    end else begin
      ground = bus.in_z <= Z_FLR_LIM;
      mem_wr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_z_q     <= '0;
      out_gnd_q   <= 1'b0;
      ref_valid   <= '0;
    end else begin
      if (acc) begin
        out_valid_q <= 1'b1;
        out_row_q   <= bus.in_row;
        out_col_q   <= bus.in_col;
        out_x_q     <= bus.in_x;
        out_y_q     <= bus.in_y;
        out_z_q     <= bus.in_z;
        out_gnd_q   <= ground;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      for (int i = 0; i < COLS; i++) begin
        if (acc && mem_wr && (bus.in_col == COL_W'(i))) begin
          ref_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Reference payload needs no reset: it is only read when ref_valid is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < COLS; i++) begin
      if (!rst && acc && mem_wr && (bus.in_col == COL_W'(i))) begin
        ref_z[i]   <= bus.in_z;
        ref_gnd[i] <= ground;
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_row       = out_row_q;
  assign bus.out_col       = out_col_q;
  assign bus.out_x         = out_x_q;
  assign bus.out_y         = out_y_q;
  assign bus.out_z         = out_z_q;
  assign bus.out_is_ground = out_gnd_q;

endmodule

// File: tb/tb_ground_seg.sv
// Directed self-checking bench for ground_seg: continuity, references, empty/out-of-range,
// backpressure, mid-frame reset and a full 30x30 frame at one point per cycle.
module tb_ground_seg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  ground_seg_if #(.W(16), .COL_W(5)) bus ();

  ground_seg #(
    .W(16), .COLS(30), .COL_W(5), .Z_GND_MAX(5), .DZ_MAX(2), .Z_FLOOR(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // Drives one point for one accept edge with out_ready=1 and returns what was observed.
  // Entered and left at posedge+1.
  task automatic push(input logic [7:0] row, input logic [4:0] col,
                      input logic signed [15:0] x, input logic signed [15:0] y,
                      input logic signed [15:0] z,
                      output logic rdy, output logic vld, output logic gnd,
                      output logic [60:0] fwd);
    bus.in_valid  = 1'b1;
    bus.in_row    = row;
    bus.in_col    = col;
    bus.in_x      = x;
    bus.in_y      = y;
    bus.in_z      = z;
    bus.out_ready = 1'b1;
    #1;
    rdy = bus.in_ready;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    vld = bus.out_valid;
    gnd = bus.out_is_ground;
    fwd = {bus.out_row, bus.out_col, bus.out_x, bus.out_y, bus.out_z};
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_row = '0; bus.in_col = '0; bus.in_x = '0; bus.in_y = '0; bus.in_z = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_is_ground !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got vld=%b gnd=%b want 0 0", bus.out_valid, bus.out_is_ground);
    end
    checks++;
    if ({bus.out_row, bus.out_col, bus.out_x, bus.out_y, bus.out_z} !== 61'd0) begin
      failures++;
      $display("FAIL reset_fields got %h want 0",
               {bus.out_row, bus.out_col, bus.out_x, bus.out_y, bus.out_z});
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    rst = 1'b0;
  endtask

  // Runs a vector table through push and checks each result inline.
  task automatic run_table(input string tag, input int n,
                           input logic [7:0] rows [8], input logic [4:0] cols [8],
                           input logic signed [15:0] xs [8], input logic signed [15:0] zs [8],
                           input logic exp [8]);
    logic rdy, vld, gnd;
    logic [60:0] fwd;
    for (int i = 0; i < n; i++) begin
      push(rows[i], cols[i], xs[i], xs[i], zs[i], rdy, vld, gnd, fwd);
      checks++;
      if (rdy !== 1'b1 || vld !== 1'b1) begin
        failures++;
        $display("FAIL %s[%0d] handshake got rdy=%b vld=%b want 1 1", tag, i, rdy, vld);
      end
      checks++;
      if (gnd !== exp[i]) begin
        failures++;
        $display("FAIL %s[%0d] is_ground got %b want %b", tag, i, gnd, exp[i]);
      end
      checks++;
      if (fwd !== {rows[i], cols[i], xs[i], xs[i], zs[i]}) begin
        failures++;
        $display("FAIL %s[%0d] forward got %h want %h", tag, i, fwd,
                 {rows[i], cols[i], xs[i], xs[i], zs[i]});
      end
    end
  endtask

  task automatic test_continuity();
    logic [7:0] rows [8];
    logic [4:0] cols [8];
    logic signed [15:0] xs [8];
    logic signed [15:0] zs [8];
    logic exp [8];
    rows = '{0, 1, 0, 1, 0, 1, 0, 0};
    cols = '{3, 3, 3, 3, 5, 5, 0, 0};
    xs   = '{7, 7, 7, 7, 1, 1, 0, 0};
    zs   = '{4, 5, 0, 5, -100, -97, 0, 0};
    exp  = '{1, 1, 1, 0, 1, 0, 0, 0};
    run_table("continuity", 6, rows, cols, xs, zs, exp);
  endtask

  task automatic test_nonground_ref();
    logic [7:0] rows [8];
    logic [4:0] cols [8];
    logic signed [15:0] xs [8];
    logic signed [15:0] zs [8];
    logic exp [8];
    rows = '{0, 1, 2, 3, 0, 0, 0, 0};
    cols = '{7, 7, 7, 7, 0, 0, 0, 0};
    xs   = '{2, 2, 2, 2, 0, 0, 0, 0};
    zs   = '{9, 3, 1, 3, 0, 0, 0, 0};
    exp  = '{0, 0, 1, 1, 0, 0, 0, 0};
    run_table("nongnd_ref", 4, rows, cols, xs, zs, exp);
  endtask

  task automatic test_empty_oor();
    logic [7:0] rows [8];
    logic [4:0] cols [8];
    logic signed [15:0] xs [8];
    logic signed [15:0] zs [8];
    logic exp [8];
    // Empty point must not overwrite col 4; col 31 is out of range and touches nothing.
    rows = '{0, 1, 2, 3, 4, 0, 0, 0};
    cols = '{4, 4, 4, 31, 4, 0, 0, 0};
    xs   = '{3, 0, 3, 3, 3, 0, 0, 0};
    zs   = '{20, 0, 21, 100, 2, 0, 0, 0};
    exp  = '{0, 1, 0, 1, 1, 0, 0, 0};
    run_table("empty_oor", 5, rows, cols, xs, zs, exp);
  endtask

  task automatic test_backpressure();
    logic signed [15:0] zs [4];
    logic exp [4];
    logic [60:0] held;
    zs  = '{3, 6, 5, -1};
    exp = '{1, 0, 1, 1};
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_row = 8'd0; bus.in_col = 5'd12;
    bus.in_x = 16'sd1; bus.in_y = 16'sd2; bus.in_z = zs[0];
    @(posedge clk); #1;
    held = {bus.out_row, bus.out_col, bus.out_x, bus.out_y, bus.out_z};
    checks++;
    if (bus.out_valid !== 1'b1 || held !== {8'd0, 5'd12, 16'sd1, 16'sd2, zs[0]}
        || bus.out_is_ground !== exp[0]) begin
      failures++;
      $display("FAIL bp_first got vld=%b fwd=%h gnd=%b want 1 %h %b", bus.out_valid, held,
               bus.out_is_ground, {8'd0, 5'd12, 16'sd1, 16'sd2, zs[0]}, exp[0]);
    end
    bus.out_ready = 1'b0;
    bus.in_col = 5'd13; bus.in_z = zs[1];
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall_ready[%0d] got %b want 0", c, bus.in_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_is_ground !== exp[0] ||
          {bus.out_row, bus.out_col, bus.out_x, bus.out_y, bus.out_z} !== held) begin
        failures++;
        $display("FAIL bp_stall_hold[%0d] got vld=%b fwd=%h want 1 %h", c, bus.out_valid,
                 {bus.out_row, bus.out_col, bus.out_x, bus.out_y, bus.out_z}, held);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_is_ground !== exp[i] ||
          {bus.out_row, bus.out_col, bus.out_x, bus.out_y, bus.out_z} !==
          {8'd0, 5'(12 + i), 16'sd1, 16'sd2, zs[i]}) begin
        failures++;
        $display("FAIL bp_drain[%0d] got vld=%b col=%0d z=%0d gnd=%b want 1 %0d %0d %b", i,
                 bus.out_valid, bus.out_col, bus.out_z, bus.out_is_ground, 12 + i, zs[i], exp[i]);
      end
      if (i < 3) begin
        bus.in_col = 5'(13 + i);
        bus.in_z   = zs[i+1];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_midframe();
    logic rdy, vld, gnd;
    logic [60:0] fwd;
    push(8'd0, 5'd2, 16'sd1, 16'sd1, 16'sd0, rdy, vld, gnd, fwd);
    checks++;
    if (vld !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre got out_valid=%b want 1", vld);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_is_ground !== 1'b0 ||
        {bus.out_row, bus.out_col, bus.out_x, bus.out_y, bus.out_z} !== 61'd0) begin
      failures++;
      $display("FAIL rst_mid_clear got vld=%b gnd=%b z=%0d want 0 0 0", bus.out_valid,
               bus.out_is_ground, bus.out_z);
    end
    push(8'd1, 5'd2, 16'sd1, 16'sd1, 16'sd8, rdy, vld, gnd, fwd);
    checks++;
    if (vld !== 1'b1 || gnd !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_col2 got vld=%b gnd=%b want 1 0", vld, gnd);
    end
    // Col 3 held a non-ground ref before reset; after reset z=4 must use the plain height test.
    push(8'd1, 5'd3, 16'sd1, 16'sd1, 16'sd4, rdy, vld, gnd, fwd);
    checks++;
    if (vld !== 1'b1 || gnd !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_col3 got vld=%b gnd=%b want 1 1", vld, gnd);
    end
  endtask

  task automatic test_back_to_back();
    logic rdy, vld, gnd;
    logic [60:0] fwd;
    logic signed [15:0] z;
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < 30; c++) begin
        z = ((r + c) % 2 == 0) ? 16'sd1 : 16'sd2;
        push(8'(r), 5'(c), 16'sd5, 16'sd6, z, rdy, vld, gnd, fwd);
        checks++;
        if (rdy !== 1'b1 || vld !== 1'b1 || gnd !== 1'b1 ||
            fwd !== {8'(r), 5'(c), 16'sd5, 16'sd6, z}) begin
          failures++;
          $display("FAIL frame r=%0d c=%0d got rdy=%b vld=%b gnd=%b fwd=%h want 1 1 1", r, c,
                   rdy, vld, gnd, fwd);
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL frame_end got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_continuity();
    test_nonground_ref();
    test_empty_oor();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
